matmul_feeder: RTL and testbench

- Upstream/downstream controller for the 2x2 systolic multiply stage.
- Accepts operand bytes over a valid/ready stream and assembles matrices A and B, then drives them and start to the array.
- Holds start until the array pulses done, captures C, and streams C back out over a valid/ready stream.
- Gives the array a simple byte-serial host interface with a timeout guard.

---
 rtl/tpu_pkg.sv | 8 +
 rtl/stream_serializer4.sv | 28 ++
 rtl/matmul_feeder.sv | 81 ++++++++
 tb/tb_matmul_feeder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared element/matrix types and feeder state encoding for the 2x2 systolic stage.
package tpu_pkg;
  localparam int DATA_W = 8;
  localparam int N = 2;
  typedef logic [DATA_W-1:0] elem_t;
  typedef elem_t mat2_t [N][N];
  typedef enum logic [1:0] {LOAD, RUN, DRAIN} feeder_state_t;
endpackage

// File: rtl/stream_serializer4.sv
// stream_serializer4: captures a 2x2 result matrix and unloads it row-major one byte per valid/ready transfer.
module stream_serializer4
  import tpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  mat2_t c,
  input  logic  active,
  input  logic  ready,
  output elem_t data,
  output logic  last
);
  elem_t res [4];
  logic [1:0] idx;
  logic fire;
  assign fire = active && ready;
  assign last = fire && idx == 2'd3;
  assign data = res[idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      for (int i = 0; i < 4; i++) res[i] <= '0;
    end else begin
      if (load) for (int i = 0; i < 4; i++) res[i] <= c[i/2][i%2];
      if (fire) idx <= last ? 2'd0 : idx + 2'd1;
    end
endmodule

// File: rtl/matmul_feeder.sv
// matmul_feeder: assembles A/B from a byte stream, runs the 2x2 array with a timeout guard, streams C back out.
module matmul_feeder
  import tpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT+1)
) (
  input  logic  clk,
  input  logic  rst,
  input  elem_t in_data,
  input  logic  in_valid,
  output logic  in_ready,
  output elem_t out_data,
  output logic  out_valid,
  input  logic  out_ready,
  output mat2_t a_o,
  output mat2_t b_o,
  output logic  start_o,
  input  mat2_t c_i,
  input  logic  done_i,
  output logic  busy,
  output logic  timeout_err,
  input  logic  clr_err
);
  feeder_state_t state;
  logic [2:0] in_idx;
  logic [TO_W-1:0] run_cnt;
  logic last;
  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy      = state != LOAD;
  stream_serializer4 u_ser (
    .clk(clk),
    .rst(rst),
    .load(state == RUN && done_i),
    .c(c_i),
    .active(out_valid),
    .ready(out_ready),
    .data(out_data),
    .last(last)
  );
  // timeout_err clear is applied first so a same-cycle set overrides it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= LOAD;
      in_idx      <= '0;
      run_cnt     <= '0;
      start_o     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_o[i][j] <= '0;
          b_o[i][j] <= '0;
        end
    end else begin
      if (clr_err) timeout_err <= 1'b0;
      case (state)
        LOAD: if (in_valid) begin
          if (in_idx[2]) b_o[in_idx[1]][in_idx[0]] <= in_data;
          else a_o[in_idx[1]][in_idx[0]] <= in_data;
          in_idx <= in_idx == 3'd7 ? 3'd0 : in_idx + 3'd1;
          if (in_idx == 3'd7) begin
            state   <= RUN;
            start_o <= 1'b1;
          end
        end
        RUN: if (done_i) begin
          start_o <= 1'b0;
          run_cnt <= '0;
          state   <= DRAIN;
        end else if (run_cnt == TO_W'(TIMEOUT-1)) begin
          timeout_err <= 1'b1;
          start_o     <= 1'b0;
          run_cnt     <= '0;
          state       <= LOAD;
        end else run_cnt <= run_cnt + 1'b1;
        DRAIN: if (last) state <= LOAD;
        default: state <= LOAD;
      endcase
    end
endmodule

// File: tb/tb_matmul_feeder.sv
// tb_matmul_feeder: directed job sequence with random operands against a stub 2x2 array and a queue-based model.
module tb_matmul_feeder;
  import tpu_pkg::*;
  logic clk = 0, rst = 1;
  elem_t in_data = '0, out_data;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  mat2_t a_o, b_o, c_i;
  logic start_o, done_i = 0, busy, timeout_err, clr_err = 0;
  int compared = 0, mismatched = 0;
  elem_t ops [8];
  elem_t stub_c [4];
  int done_at = 4;
  int run_cycles = 0;

  matmul_feeder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .a_o(a_o), .b_o(b_o), .start_o(start_o), .c_i(c_i), .done_i(done_i),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // stub array: done pulses in the done_at-th cycle of start_o; c_i is junk except in that cycle
  always @(posedge clk) begin
    #1;
    if (start_o) run_cycles++;
    else run_cycles = 0;
    done_i = start_o && done_at != 0 && run_cycles == done_at;
    for (int k = 0; k < 4; k++) c_i[k/2][k%2] = done_i ? stub_c[k] : elem_t'($urandom);
  end

  function automatic logic [31:0] pk(input mat2_t m);
    return {m[0][0], m[0][1], m[1][0], m[1][1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_job(input int d);
    for (int i = 0; i < 8; i++) ops[i] = elem_t'($urandom);
    for (int k = 0; k < 4; k++) stub_c[k] = elem_t'($urandom);
    done_at = d;
  endtask

  task automatic load_bytes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      in_valid = 0;
      repeat ($urandom_range(gap, 0)) step();
      chk("in_ready_load", in_ready, 1);
      in_valid = 1;
      in_data = ops[i];
      step();
    end
    in_valid = 0;
  endtask

  task automatic run_phase(input int exp_run, input bit clr_run);
    int n = 0;
    in_valid = 1;
    in_data = elem_t'($urandom);
    while (start_o && n < 40) begin
      chk("a_run", pk(a_o), {ops[0], ops[1], ops[2], ops[3]});
      chk("b_run", pk(b_o), {ops[4], ops[5], ops[6], ops[7]});
      chk("in_ready_run", in_ready, 0);
      chk("busy_run", busy, 1);
      clr_err = clr_run;
      n++;
      step();
    end
    clr_err = 0;
    chk("run_len", n, exp_run);
  endtask

  task automatic drain_phase(input bit bp, input int stop_after);
    elem_t got [$];
    elem_t held = '0;
    bit stalled = 0;
    int t = 0;
    chk("first_valid", out_valid, 1);
    while (got.size() < stop_after && t < 60) begin
      out_ready = bp ? (t % 3 == 0) : 1'b1;
      chk("out_valid_drain", out_valid, 1);
      chk("in_ready_drain", in_ready, 0);
      if (stalled) chk("stall_hold", out_data, held);
      if (out_ready) got.push_back(out_data);
      stalled = !out_ready;
      held = out_data;
      if (got.size() == 4) in_valid = 0;
      t++;
      step();
    end
    out_ready = 1;
    chk("xfer_count", got.size(), stop_after);
    for (int k = 0; k < got.size(); k++) chk($sformatf("c%0d", k), got[k], stub_c[k]);
    if (stop_after == 4) begin
      chk("drain_cycles", t, bp ? 10 : 4);
      chk("out_valid_done", out_valid, 0);
      chk("in_ready_done", in_ready, 1);
      chk("busy_done", busy, 0);
    end
  endtask

  task automatic full_job(input int gap, input bit bp, input int d);
    load_bytes(8, gap);
    run_phase(d, 0);
    drain_phase(bp, 4);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_start"}, start_o, 0);
    chk({tag, "_a"}, pk(a_o), 0);
    chk({tag, "_b"}, pk(b_o), 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_od"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_terr"}, timeout_err, 0);
  endtask

  initial begin
    step();
    step();
    reset_checks("por");
    rst = 0;
    step();
    chk("in_ready_por", in_ready, 1);

    // basic job with the reference stub values
    for (int i = 0; i < 8; i++) ops[i] = elem_t'(i + 1);
    stub_c[0] = 8'h13; stub_c[1] = 8'h16; stub_c[2] = 8'h2B; stub_c[3] = 8'h32;
    done_at = 4;
    full_job(0, 0, 4);
    chk("terr_basic", timeout_err, 0);

    new_job(4); full_job(0, 1, 4);
    new_job(4); full_job(3, 0, 4);
    for (int r = 0; r < 3; r++) begin
      new_job($urandom_range(15, 1));
      full_job(2, r[0], done_at);
    end

    // timeout, then clear
    new_job(0);
    load_bytes(8, 1);
    run_phase(16, 0);
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("terr_set", timeout_err, 1);
      chk("ov_timeout", out_valid, 0);
      chk("in_ready_timeout", in_ready, 1);
      chk("start_timeout", start_o, 0);
      step();
    end
    clr_err = 1;
    step();
    clr_err = 0;
    chk("terr_clr", timeout_err, 0);

    // timeout with clr_err held through the setting cycle: set wins
    new_job(0);
    load_bytes(8, 0);
    run_phase(16, 1);
    in_valid = 0;
    chk("terr_set_wins", timeout_err, 1);

    // async reset after 5 bytes
    new_job(4);
    load_bytes(5, 1);
    #2 rst = 1;
    #1 reset_checks("rst_load");
    rst = 0;
    step();
    new_job(4); full_job(1, 0, 4);

    // async reset mid-drain
    new_job(4);
    load_bytes(8, 0);
    run_phase(4, 0);
    drain_phase(1, 2);
    #2 rst = 1;
    #1 reset_checks("rst_drain");
    in_valid = 0;
    rst = 0;
    step();
    new_job(4); full_job(0, 0, 4);

    // done_i in the last allowed RUN cycle takes priority over timeout
    new_job(16);
    full_job(0, 0, 16);
    chk("terr_coincide", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
